transfer_rx: RTL and testbench
==============================

Name: transfer_rx

Overview:
- Receiving end of the scanner-to-scanner byte transfer.
- Accepts bytes from the peer scanner over a 4-phase valid/ack handshake during a transfer session opened by start_transfer.
- Buffers received bytes in a FIFO; the CPU drains the FIFO through the read_inc PIO strobe, and the head byte is presented on data_out_cpu.
- Sits beside the scanner datapath in the top-level network system, between the peer link and the Nios PIO ports.

Parameters:
- DATA_W, 8, byte width of the transfer and CPU data path.
- DEPTH, 8, FIFO entries; must be a power of 2.
- AW, 3, pointer width; AW = log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous active-low reset.
- start_transfer  in  1  level from the CPU/peer; high = session open.
- data_in  in  DATA_W  byte from the peer; stable while data_valid is high.
- data_valid  in  1  peer byte-valid (4-phase request).
- data_ack  out  1  byte accepted (4-phase acknowledge).
- read_inc  in  1  CPU pop strobe, level from PIO; internally edge-detected.
- data_out_cpu  out  DATA_W  FIFO head byte; 0 when empty.
- count  out  AW+1  number of bytes held, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- ready_to_transfer  out  1  high when state is IDLE and not full.
- xfer_done  out  1  one-cycle pulse at session end.
- state  out  3  current FSM encoding, for debug/LED display.

Behaviour:
Reset (rst low, asynchronous):
- Pointers and count go to 0; FSM goes to IDLE.
- Outputs: data_ack=0, xfer_done=0, empty=1, full=0, data_out_cpu=0, ready_to_transfer=1.
- The read_inc edge-detect register resets to 0.
- FIFO contents are don't-care.

FSM encoding: IDLE=0, RECV=1, ACK=2, DONE=3.
- IDLE:
  - start_transfer=1 → RECV on the next edge.
- RECV:
  - data_valid=1 and !full → write data_in at wr_ptr, wr_ptr+1 (mod DEPTH), → ACK. The write happens on this edge.
  - data_valid=1 and full → stay in RECV with no write and data_ack=0 (backpressure). The peer holds its byte.
  - data_valid=0 and start_transfer=0 → DONE.
  - data_valid=1 takes priority over start_transfer=0, so a pending byte is accepted first.
- ACK:
  - data_ack=1 (registered, asserted the cycle after the write).
  - Stays in ACK while data_valid=1.
  - data_valid=0 → RECV, and data_ack drops on that edge.
  - A byte is never written twice per valid pulse.
- DONE:
  - xfer_done=1 for exactly one cycle, then → IDLE.
- ready_to_transfer is combinational: (state==IDLE) && !full.

Read side:
- pop = read_inc & ~read_inc_q. read_inc_q is registered each cycle.
- Exactly one pop per rising edge of read_inc, however long the CPU holds it.
- pop with !empty: rd_ptr+1 (mod DEPTH). pop with empty is ignored.
- data_out_cpu = mem[rd_ptr] when !empty, else 0. It is first-word fall-through: a byte is visible the cycle after its write edge.

Count:
- Write only: +1. Pop only: −1. Write and pop on the same edge: unchanged, both pointers advance.
- A pop and a write in the same cycle while full is allowed. The write decision uses pre-edge full, so a write while full is still blocked.

Reset mid-session:
- Aborts immediately to the reset values; no xfer_done pulse.

Test Plan:
- Reset, then start_transfer=1, then send 3 bytes 0x11, 0x22, 0x33 with full 4-phase handshakes → each data_ack rises 1 cycle after its valid and falls after valid drops; count=3; data_out_cpu=0x11.
- Drop start_transfer with no valid pending → state 1→3→0, xfer_done high exactly 1 cycle, ready_to_transfer=1 again.
- Hold read_inc high for 5 cycles, then low, then pulse again → exactly two pops; data_out_cpu goes 0x11→0x22→0x33; count=1.
- Fill 8 bytes 0x01..0x08 → full=1, ready_to_transfer=0 after the session ends. A 9th byte 0x09 with valid held → no ack, count=8. One pop → 0x09 accepted, ack issued, count=8, head=0x02.
- Make a pop edge coincide with a write edge at count=4 → count stays 4, head advances; pointer wrap past entry 7 reads back in correct order.
- Assert rst low in ACK state with count=5 → count=0, empty=1, data_ack=0, state=0 asynchronously, with no xfer_done pulse.

Source files
------------

// File: rtl/transfer_rx.sv
// Purpose: receive side of the scanner-to-scanner byte link; buffers peer bytes for CPU PIO reads.
// Latency: data_ack rises one cycle after valid is seen in RECV; a byte appears on data_out_cpu the cycle after its write.
// Backpressure: when the FIFO is full, data_ack is withheld and the peer holds its byte until a CPU pop frees an entry.
module transfer_rx #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_transfer,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ack,
  input  logic              read_inc,
  output logic [DATA_W-1:0] data_out_cpu,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              ready_to_transfer,
  output logic              xfer_done,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RECV = 3'd1,
    ACK  = 3'd2,
    DONE = 3'd3
  } state_t;

  state_t            cur_state;
  state_t            nxt_state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              read_inc_q;
  logic              wr_en;
  logic              pop;

  assign full  = (cnt == (AW + 1)'(DEPTH));
  assign empty = (cnt == '0);

  // A long CPU strobe pops only once: only its rising edge counts, and a pop on empty is dropped.
  assign pop = read_inc & ~read_inc_q & ~empty;

  // Handshake sequencing: a pending byte wins over session close; full blocks the write but not the session.
  always_comb begin
    nxt_state = cur_state;
    wr_en     = 1'b0;
    case (cur_state)
      IDLE: begin
        if (start_transfer) nxt_state = RECV;
      end
      RECV: begin
        if (data_valid) begin
          if (!full) begin
            wr_en     = 1'b1;
            nxt_state = ACK;
          end
        end else if (!start_transfer) begin
          nxt_state = DONE;
        end
      end
      ACK: begin
        // Waiting here until valid drops guarantees one write per valid pulse.
        if (!data_valid) nxt_state = RECV;
      end
      DONE: begin
        nxt_state = IDLE;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // State register; reset aborts any session without passing through DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur_state <= IDLE;
    else      cur_state <= nxt_state;
  end

  // Read-strobe history for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) read_inc_q <= 1'b0;
    else      read_inc_q <= read_inc;
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy including simultaneous push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign data_out_cpu      = empty ? '0 : mem[rd_ptr];
  assign count             = cnt;
  assign data_ack          = (cur_state == ACK);
  assign xfer_done         = (cur_state == DONE);
  assign ready_to_transfer = (cur_state == IDLE) && !full;
  assign state             = cur_state;

endmodule

// File: tb/tb_transfer_rx.sv
module tb_transfer_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_transfer = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ack;
  logic       read_inc = 1'b0;
  logic [7:0] data_out_cpu;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       ready_to_transfer;
  logic       xfer_done;
  logic [2:0] state;

  int n_cmp  = 0;
  int n_fail = 0;

  transfer_rx #(.DATA_W(8), .DEPTH(8), .AW(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .start_transfer    (start_transfer),
    .data_in           (data_in),
    .data_valid        (data_valid),
    .data_ack          (data_ack),
    .read_inc          (read_inc),
    .data_out_cpu      (data_out_cpu),
    .count             (count),
    .full              (full),
    .empty             (empty),
    .ready_to_transfer (ready_to_transfer),
    .xfer_done         (xfer_done),
    .state             (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, vld, rd, dat;
    int e_state, e_ack, e_cnt, e_head, e_done, e_rdy;
  } vec_t;

  vec_t tbl [18];
  logic [7:0] q [$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fifo(input string tag, input int exp_cnt, input int exp_head);
    chk({tag, "_count"}, int'(count), exp_cnt);
    chk({tag, "_empty"}, int'(empty), int'(exp_cnt == 0));
    chk({tag, "_full"}, int'(full), int'(exp_cnt == 8));
    chk({tag, "_head"}, int'(data_out_cpu), exp_head);
  endtask

  // Full 4-phase handshake; the FIFO must have room and the DUT must be in RECV.
  task automatic send(input logic [7:0] b);
    int n;
    data_in = b;
    data_valid = 1'b1;
    n = 0;
    do begin step(); n++; end while (!data_ack && n < 8);
    chk("ack_rise_latency", n, 1);
    data_valid = 1'b0;
    n = 0;
    do begin step(); n++; end while (data_ack && n < 8);
    chk("ack_fall_latency", n, 1);
  endtask

  task automatic pulse_read(input int hold);
    read_inc = 1'b1;
    repeat (hold) step();
    read_inc = 1'b0;
    step();
  endtask

  task automatic open_session();
    start_transfer = 1'b1;
    step();
    chk("open_state", int'(state), 1);
  endtask

  task automatic close_session();
    start_transfer = 1'b0;
    step();
    chk("close_state_done", int'(state), 3);
    chk("close_xfer_done", int'(xfer_done), 1);
    step();
    chk("close_state_idle", int'(state), 0);
    chk("close_xfer_done_low", int'(xfer_done), 0);
  endtask

  initial begin
    int n;
    int exp_cnt;
    logic [7:0] b;

    //         st vld rd dat   state ack cnt head  done rdy
    tbl[0]  = '{1, 0, 0, 'h00,  1, 0, 0, 'h00, 0, 0};
    tbl[1]  = '{1, 1, 0, 'h11,  2, 1, 1, 'h11, 0, 0};
    tbl[2]  = '{1, 0, 0, 'h00,  1, 0, 1, 'h11, 0, 0};
    tbl[3]  = '{1, 1, 0, 'h22,  2, 1, 2, 'h11, 0, 0};
    tbl[4]  = '{1, 0, 0, 'h00,  1, 0, 2, 'h11, 0, 0};
    tbl[5]  = '{1, 1, 0, 'h33,  2, 1, 3, 'h11, 0, 0};
    tbl[6]  = '{1, 1, 0, 'h33,  2, 1, 3, 'h11, 0, 0};
    tbl[7]  = '{1, 0, 0, 'h00,  1, 0, 3, 'h11, 0, 0};
    tbl[8]  = '{0, 0, 0, 'h00,  3, 0, 3, 'h11, 1, 0};
    tbl[9]  = '{0, 0, 0, 'h00,  0, 0, 3, 'h11, 0, 1};
    tbl[10] = '{0, 0, 1, 'h00,  0, 0, 2, 'h22, 0, 1};
    tbl[11] = '{0, 0, 1, 'h00,  0, 0, 2, 'h22, 0, 1};
    tbl[12] = '{0, 0, 1, 'h00,  0, 0, 2, 'h22, 0, 1};
    tbl[13] = '{0, 0, 1, 'h00,  0, 0, 2, 'h22, 0, 1};
    tbl[14] = '{0, 0, 1, 'h00,  0, 0, 2, 'h22, 0, 1};
    tbl[15] = '{0, 0, 0, 'h00,  0, 0, 2, 'h22, 0, 1};
    tbl[16] = '{0, 0, 1, 'h00,  0, 0, 1, 'h33, 0, 1};
    tbl[17] = '{0, 0, 0, 'h00,  0, 0, 1, 'h33, 0, 1};

    // Reset values while reset is held.
    repeat (2) step();
    chk("rst_state", int'(state), 0);
    chk("rst_ack", int'(data_ack), 0);
    chk("rst_done", int'(xfer_done), 0);
    chk("rst_rdy", int'(ready_to_transfer), 1);
    chk_fifo("rst", 0, 0);
    rst = 1'b1;
    step();

    // Three-byte session, close, then a held read strobe and a second pulse.
    for (int i = 0; i < 18; i++) begin
      start_transfer = tbl[i].st[0];
      data_valid     = tbl[i].vld[0];
      read_inc       = tbl[i].rd[0];
      data_in        = tbl[i].dat[7:0];
      step();
      chk($sformatf("v%0d_state", i), int'(state), tbl[i].e_state);
      chk($sformatf("v%0d_ack", i), int'(data_ack), tbl[i].e_ack);
      chk($sformatf("v%0d_count", i), int'(count), tbl[i].e_cnt);
      chk($sformatf("v%0d_head", i), int'(data_out_cpu), tbl[i].e_head);
      chk($sformatf("v%0d_done", i), int'(xfer_done), tbl[i].e_done);
      chk($sformatf("v%0d_rdy", i), int'(ready_to_transfer), tbl[i].e_rdy);
    end

    // Drain to empty, then a pop on empty must be ignored.
    pulse_read(1);
    chk_fifo("drain", 0, 0);
    pulse_read(2);
    chk_fifo("pop_empty", 0, 0);

    // Fill to DEPTH; readiness drops once the session ends with a full FIFO.
    open_session();
    for (int i = 1; i <= 8; i++) send(8'(i));
    close_session();
    chk_fifo("filled", 8, 'h01);
    chk("filled_rdy", int'(ready_to_transfer), 0);

    // Ninth byte is held off until a pop frees an entry.
    open_session();
    data_in = 8'h09;
    data_valid = 1'b1;
    repeat (4) step();
    chk("bp_ack", int'(data_ack), 0);
    chk("bp_state", int'(state), 1);
    chk_fifo("bp", 8, 'h01);
    read_inc = 1'b1;
    step();
    read_inc = 1'b0;
    chk_fifo("bp_pop", 7, 'h02);
    n = 0;
    do begin step(); n++; end while (!data_ack && n < 8);
    chk("bp_ack_latency", n, 1);
    chk_fifo("bp_accept", 8, 'h02);
    data_valid = 1'b0;
    step();
    chk("bp_ack_drop", int'(data_ack), 0);

    // Down to four entries, then a pop edge coinciding with a write edge.
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("drain4_head_%0d", k), int'(data_out_cpu), k);
      pulse_read(1);
    end
    chk_fifo("at4", 4, 'h06);
    data_in = 8'hA0;
    data_valid = 1'b1;
    read_inc = 1'b1;
    step();
    chk_fifo("coincide", 4, 'h07);
    chk("coincide_ack", int'(data_ack), 1);
    data_valid = 1'b0;
    read_inc = 1'b0;
    step();
    chk("coincide_ack_drop", int'(data_ack), 0);

    // Read order across the pointer wrap.
    q = '{8'h07, 8'h08, 8'h09, 8'hA0};
    exp_cnt = 4;
    while (q.size() > 0) begin
      chk("wrap_head", int'(data_out_cpu), int'(q[0]));
      pulse_read(1);
      void'(q.pop_front());
      exp_cnt--;
      chk("wrap_count", int'(count), exp_cnt);
    end

    // Reset asserted mid-handshake with five bytes held.
    for (int i = 0; i < 4; i++) send(8'(8'h31 + i));
    data_in = 8'h35;
    data_valid = 1'b1;
    step();
    chk("pre_rst_state", int'(state), 2);
    chk("pre_rst_count", int'(count), 5);
    #2 rst = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_ack", int'(data_ack), 0);
    chk("arst_done", int'(xfer_done), 0);
    chk_fifo("arst", 0, 0);
    data_valid = 1'b0;
    step();
    chk("arst_hold_done", int'(xfer_done), 0);
    rst = 1'b1;
    step();
    chk("post_rst_state", int'(state), 1);
    chk("post_rst_done", int'(xfer_done), 0);

    // Randomised traffic against a plain queue model of the buffered bytes.
    q.delete();
    for (int op_i = 0; op_i < 250; op_i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 5 && q.size() < 8) begin
        b = 8'($urandom_range(0, 255));
        send(b);
        q.push_back(b);
      end else if (op < 9 || q.size() == 8) begin
        pulse_read($urandom_range(1, 4));
        if (q.size() > 0) void'(q.pop_front());
      end else begin
        close_session();
        chk("rnd_rdy", int'(ready_to_transfer), int'(q.size() < 8));
        open_session();
      end
      chk_fifo("rnd", q.size(), (q.size() > 0) ? int'(q[0]) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
